serial_adder_using_full_adder: RTL

//  Bit-serial WIDTH-bit adder built around one full_adder cell and a carry flip-flop.

---
 rtl/serial_adder_using_full_adder.sv | 111 +++++++++++
 1 files changed

// File: rtl/serial_adder_using_full_adder.sv
// Bit-serial WIDTH-bit adder: one full-adder cell plus a carry flip-flop, LSB first.
// Optional macro OVERFLOW_FLAG_EN adds a registered signed-overflow output Ovf.

module full_adder (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic sum,
   output logic cout
);
   assign sum  = a ^ b ^ cin;
   assign cout = (a & b) | (cin & (a ^ b));
endmodule

module serial_adder_using_full_adder #(
   parameter int WIDTH = 8
) (
   input  logic             Clk,
   input  logic             Rst,
   input  logic             Start,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             Cin,
   output logic             Busy,
   output logic             Done,
   output logic [WIDTH-1:0] Sum,
   output logic             Cout
`ifdef OVERFLOW_FLAG_EN
   ,
   output logic             Ovf
`endif
);
   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_SHIFT = 2'd1;
   localparam logic [1:0] S_DONE  = 2'd2;

   logic [1:0]       state_reg;
   logic [WIDTH-1:0] a_sr_reg;
   logic [WIDTH-1:0] b_sr_reg;
   logic [WIDTH-1:0] res_sr_reg;
   logic [CW-1:0]    count_reg;
   logic             carry_reg;
   logic             fa_sum;
   logic             fa_cout;
   logic             last_bit;
   logic [WIDTH-1:0] res_next;

   full_adder u_fa (
      .a    (a_sr_reg[0]),
      .b    (b_sr_reg[0]),
      .cin  (carry_reg),
      .sum  (fa_sum),
      .cout (fa_cout)
   );

   assign last_bit = (count_reg == CW'(WIDTH - 1));
   assign res_next = {fa_sum, res_sr_reg[WIDTH-1:1]};
   assign Busy     = (state_reg == S_SHIFT);
   assign Done     = (state_reg == S_DONE);

   always_ff @(posedge Clk) begin
      if (Rst) begin
         state_reg  <= S_IDLE;
         a_sr_reg   <= '0;
         b_sr_reg   <= '0;
         res_sr_reg <= '0;
         count_reg  <= '0;
         carry_reg  <= 1'b0;
         Sum        <= '0;
         Cout       <= 1'b0;
`ifdef OVERFLOW_FLAG_EN
         Ovf        <= 1'b0;
`endif
      end else begin
         case (state_reg)
            // DONE accepts a new request exactly like IDLE, giving back-to-back operation
            S_IDLE, S_DONE: begin
               if (Start) begin
                  a_sr_reg   <= A;
                  b_sr_reg   <= B;
                  res_sr_reg <= '0;
                  carry_reg  <= Cin;
                  count_reg  <= '0;
                  state_reg  <= S_SHIFT;
               end else begin
                  state_reg  <= S_IDLE;
               end
            end
            S_SHIFT: begin
               a_sr_reg   <= a_sr_reg >> 1;
               b_sr_reg   <= b_sr_reg >> 1;
               res_sr_reg <= res_next;
               carry_reg  <= fa_cout;
               count_reg  <= count_reg + CW'(1);
               if (last_bit) begin
                  // Results are published only here, so outputs never show partial sums
                  state_reg <= S_DONE;
                  Sum       <= res_next;
                  Cout      <= fa_cout;
`ifdef OVERFLOW_FLAG_EN
                  Ovf       <= carry_reg ^ fa_cout;
`endif
               end
            end
            default: state_reg <= S_IDLE;
         endcase
      end
   end
endmodule
